// File: rtl/line_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_buffer : raster pixel stream -> HEIGHT_NB-tall vertical pixel columns
// Revision    : 1.0
// ---------------------------------------------------------------------------
module line_buffer #(
  parameter int HEIGHT_NB  = 3,
  parameter int IMG_WIDTH  = 8,
  parameter int LINE_WIDTH = 640
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [IMG_WIDTH-1:0]           up_img,
  input  logic                           up_val,
  input  logic                           up_sof,
  output logic [HEIGHT_NB*IMG_WIDTH-1:0] dn_img,
  output logic                           dn_val
);

  localparam int COL_W = $clog2(LINE_WIDTH);
  localparam int ROW_W = $clog2(HEIGHT_NB);
  localparam int NMEM  = HEIGHT_NB - 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT_NB - 1);

  logic [COL_W-1:0]               col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0]               row_cnt_q, row_cnt_d;
  logic                           s1_val_q, s1_val_d;
  logic                           s1_primed_q, s1_primed_d;
  logic [IMG_WIDTH-1:0]           s1_pix_q, s1_pix_d;
  logic [COL_W-1:0]               s1_col_q, s1_col_d;
  logic                           dn_val_q, dn_val_d;
  logic [HEIGHT_NB*IMG_WIDTH-1:0] dn_img_q, dn_img_d;

  logic [COL_W-1:0]               col_eff;
  logic [ROW_W-1:0]               row_eff;
  logic [HEIGHT_NB*IMG_WIDTH-1:0] column;

  logic [IMG_WIDTH-1:0] mem_q [NMEM][LINE_WIDTH];
  logic [IMG_WIDTH-1:0] rd_q  [NMEM];

  // A start-of-frame pixel is forced to (row 0, col 0) whatever the counters hold.
  always_comb begin
    col_eff     = up_sof ? '0 : col_cnt_q;
    row_eff     = up_sof ? '0 : row_cnt_q;
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    s1_val_d    = up_val;
    s1_primed_d = s1_primed_q;
    s1_pix_d    = s1_pix_q;
    s1_col_d    = s1_col_q;
    if (up_val) begin
      s1_primed_d = (row_eff == ROW_LAST);
      s1_pix_d    = up_img;
      s1_col_d    = col_eff;
      if (col_eff == COL_LAST) begin
        col_cnt_d = '0;
        row_cnt_d = (row_eff == ROW_LAST) ? row_eff : row_eff + ROW_W'(1);
      end else begin
        col_cnt_d = col_eff + COL_W'(1);
        row_cnt_d = row_eff;
      end
    end
  end

  // Newest line in the top slice; slice 0 is the oldest line.
  always_comb begin
    column = '0;
    for (int h = 0; h < NMEM; h++) begin
      column[h*IMG_WIDTH +: IMG_WIDTH] = rd_q[NMEM-1-h];
    end
    column[NMEM*IMG_WIDTH +: IMG_WIDTH] = s1_pix_q;
    dn_val_d = s1_val_q & s1_primed_q;
    dn_img_d = dn_val_d ? column : dn_img_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      s1_val_q    <= 1'b0;
      s1_primed_q <= 1'b0;
      s1_pix_q    <= '0;
      s1_col_q    <= '0;
      dn_val_q    <= 1'b0;
      dn_img_q    <= '0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      s1_val_q    <= s1_val_d;
      s1_primed_q <= s1_primed_d;
      s1_pix_q    <= s1_pix_d;
      s1_col_q    <= s1_col_d;
      dn_val_q    <= dn_val_d;
      dn_img_q    <= dn_img_d;
    end
  end

  // Line memories shift one line deeper per write; no reset so block RAM fits.
  always_ff @(posedge clk) begin
    if (up_val) begin
      for (int k = 0; k < NMEM; k++) begin
        rd_q[k] <= mem_q[k][col_eff];
      end
    end
    if (rst && s1_val_q) begin
      mem_q[0][s1_col_q] <= s1_pix_q;
      for (int k = 1; k < NMEM; k++) begin
        mem_q[k][s1_col_q] <= rd_q[k-1];
      end
    end
  end

  assign dn_img = dn_img_q;
  assign dn_val = dn_val_q;

endmodule
`default_nettype wire
